// File: rtl/input_sram_arbiter_if.sv
// Bus between the input-activation SRAM arbiter, its requesters (one fill
// writer, NUM_READERS PE readers) and the single-port SRAM controller.
// The slave modport is the arbiter's view; master is the surrounding system.
interface input_sram_arbiter_if #(
    parameter int NUM_READERS = 4
);
    // Fill (DMA) write requester
    logic                       wr_req;
    logic [31:0]                wr_addr;
    logic [127:0]               wr_data;
    logic                       wr_ack;

    // PE-side read requesters
    logic [NUM_READERS-1:0]     rd_req;
    logic [32*NUM_READERS-1:0]  rd_addr;
    logic [NUM_READERS-1:0]     rd_ack;
    logic [127:0]               rd_data;
    logic                       err_addr;

    // SRAM controller port
    logic [31:0]                sram_w_addr;
    logic [31:0]                sram_r_addr;
    logic [127:0]               sram_w_d;
    logic                       sram_w_en;
    logic                       sram_r_en;
    logic [127:0]               sram_r_d;
    logic                       sram_d_ready;
    logic                       sram_w_done;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
               sram_r_d, sram_d_ready, sram_w_done,
        output wr_ack, rd_ack, rd_data, err_addr,
               sram_w_addr, sram_r_addr, sram_w_d, sram_w_en, sram_r_en
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
               sram_r_d, sram_d_ready, sram_w_done,
        input  wr_ack, rd_ack, rd_data, err_addr,
               sram_w_addr, sram_r_addr, sram_w_d, sram_w_en, sram_r_en
    );
endinterface

// File: rtl/input_sram_arbiter.sv
// Arbiter/sequencer sharing the input-activation SRAM controller port between
// one fill writer and NUM_READERS readers. One transaction at a time:
// IDLE (arbitrate) -> ISSUE (enable pulse) -> WAIT (controller strobe)
// -> RESP (ack pulse). Writes win unless they have held the port for
// WRITE_BURST_MAX grants while a read waits; readers rotate round-robin.
// Addresses in bank rows 6 and 7 do not exist and are answered with err_addr.
module input_sram_arbiter #(
    parameter int NUM_READERS     = 4,
    parameter int WRITE_BURST_MAX = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input_sram_arbiter_if.slave  bus
);
    localparam int         IDX_W         = $clog2(NUM_READERS);
    localparam int         STREAK_W      = $clog2(WRITE_BURST_MAX + 1);
    localparam logic [2:0] FIRST_BAD_ROW = 3'd6;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic                 op_write_q;
    logic                 err_q;
    logic [IDX_W-1:0]     reader_q;
    logic [IDX_W-1:0]     last_reader_q;
    logic [31:0]          addr_q;
    logic [127:0]         data_q;
    logic [127:0]         rd_data_q;
    logic [STREAK_W-1:0]  streak_q;

    logic                 rd_any;
    logic                 rd_found;
    logic [IDX_W-1:0]     rd_cand;
    logic [IDX_W-1:0]     rd_pick;
    logic                 streak_ok;
    logic                 grant_wr;
    logic                 grant_rd;
    logic [31:0]          grant_addr;
    logic                 grant_bad;
    logic                 op_done;

    // Round-robin search over readers, starting just after the last winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        rd_found = 1'b0;
        rd_cand  = '0;
        rd_pick  = '0;
        for (int k = 1; k <= NUM_READERS; k++) begin
            rd_cand = IDX_W'((int'(last_reader_q) + k) % NUM_READERS);
            if (!rd_found && bus.rd_req[rd_cand]) begin
                rd_found = 1'b1;
                rd_pick  = rd_cand;
            end
        end
    end

    // Grant decision in IDLE: write priority bounded by the streak limit.
    always_comb begin
        rd_any     = |bus.rd_req;
        streak_ok  = streak_q < STREAK_W'(WRITE_BURST_MAX);
        grant_wr   = (state_q == IDLE) && bus.wr_req && (streak_ok || !rd_any);
        grant_rd   = (state_q == IDLE) && !grant_wr && rd_found;
        grant_addr = grant_wr ? bus.wr_addr : bus.rd_addr[32*rd_pick +: 32];
        grant_bad  = grant_addr[13:11] >= FIRST_BAD_ROW;
        op_done    = op_write_q ? bus.sram_w_done : bus.sram_d_ready;
    end

    // State register and per-transaction capture.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            reader_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_wr || grant_rd) begin
                op_write_q <= grant_wr;
                err_q      <= grant_bad;
                reader_q   <= rd_pick;
                addr_q     <= grant_addr;
            end
            if (grant_wr) begin
                data_q <= bus.wr_data;
            end
        end
    end

    // Fairness bookkeeping: write streak and last reader served.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q      <= '0;
            last_reader_q <= IDX_W'(NUM_READERS - 1);
        end else begin
            if (grant_wr) begin
                if (streak_q != STREAK_W'(WRITE_BURST_MAX)) begin
                    streak_q <= streak_q + 1'b1;
                end
            end else if (grant_rd || (state_q == IDLE && !bus.wr_req)) begin
                streak_q <= '0;
            end
            if (grant_rd) begin
                last_reader_q <= rd_pick;
            end
        end
    end

    // Read data register: loads on read completion, zeroed by a rejected read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (state_q == WAIT && !op_write_q && bus.sram_d_ready) begin
            rd_data_q <= bus.sram_r_d;
        end else if (grant_rd && grant_bad) begin
            rd_data_q <= '0;
        end
    end

    // Next state and per-state output pulses.
    always_comb begin
        state_d       = state_q;
        bus.sram_w_en = 1'b0;
        bus.sram_r_en = 1'b0;
        bus.wr_ack    = 1'b0;
        bus.rd_ack    = '0;
        bus.err_addr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    state_d = grant_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus.sram_w_en = op_write_q;
                bus.sram_r_en = !op_write_q;
                state_d       = WAIT;
            end
            WAIT: begin
                if (op_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.wr_ack   = op_write_q;
                bus.err_addr = err_q;
                if (!op_write_q) begin
                    bus.rd_ack[reader_q] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sram_w_addr = addr_q;
    assign bus.sram_r_addr = addr_q;
    assign bus.sram_w_d    = data_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_input_sram_arbiter.sv
// Directed bench for input_sram_arbiter: write, read-back, round-robin,
// write streak limit (WRITE_BURST_MAX=2), invalid bank rows, reset in WAIT.
// A small 1-cycle controller model answers enables and stores written data.
module tb_input_sram_arbiter;
    localparam int          NR     = 4;
    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    logic clock = 1'b0;
    logic reset;
    logic ctrl_stall;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] mem [logic [31:0]];

    input_sram_arbiter_if #(.NUM_READERS(NR)) bus ();

    input_sram_arbiter #(
        .NUM_READERS    (NR),
        .WRITE_BURST_MAX(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [127:0] wdata(input int w);
        return {4{32'hC0DE_0000 + 32'(w)}};
    endfunction

    // Wait (bounded) for any ack; returns {wr_ack, rd_ack} and cycles waited.
    task automatic wait_ack(input string tag, output logic [NR:0] ack, output int n);
        ack = '0;
        n   = 0;
        while (ack == '0 && n < 40) begin
            tick();
            n++;
            ack = {bus.wr_ack, bus.rd_ack};
        end
        check({tag, "_ack_seen"}, 128'(ack != '0), 128'(1));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_acks"},  {bus.wr_ack, bus.rd_ack, bus.err_addr}, '0);
        check({tag, "_en"},    {bus.sram_w_en, bus.sram_r_en}, '0);
        check({tag, "_addr"},  {bus.sram_w_addr, bus.sram_r_addr}, '0);
        check({tag, "_wd"},    bus.sram_w_d, '0);
        check({tag, "_rdata"}, bus.rd_data, '0);
    endtask

    // One-cycle SRAM controller: strobe in the cycle after the enable.
    initial begin : controller
        logic         w_seen, r_seen;
        logic [31:0]  w_a, r_a;
        logic [127:0] w_d;
        bus.sram_w_done  = 1'b0;
        bus.sram_d_ready = 1'b0;
        bus.sram_r_d     = '0;
        forever begin
            @(negedge clock);
            w_seen = bus.sram_w_en && !ctrl_stall;
            r_seen = bus.sram_r_en && !ctrl_stall;
            w_a    = bus.sram_w_addr;
            r_a    = bus.sram_r_addr;
            w_d    = bus.sram_w_d;
            @(posedge clock);
            #1;
            bus.sram_w_done  = w_seen;
            bus.sram_d_ready = r_seen;
            bus.sram_r_d     = (r_seen && mem.exists(r_a)) ? mem[r_a] : '0;
            if (w_seen) mem[w_a] = w_d;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [NR:0]   ack;
        int            n;
        int            wcount;
        logic [NR-1:0] rr_exp [5];
        logic [NR:0]   pr_exp [6];

        rr_exp = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        pr_exp = '{5'b10000, 5'b10000, 5'b00010, 5'b10000, 5'b10000, 5'b00010};

        reset       = 1'b1;
        ctrl_stall  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
        repeat (2) tick();
        reset = 1'b0;
        check_quiet("reset");

        // Write 0x805
        bus.wr_addr = 32'h0000_0805;
        bus.wr_data = PAT_A5;
        bus.wr_req  = 1'b1;
        tick();
        check("wr_issue_wen", bus.sram_w_en, 1);
        check("wr_issue_ren", bus.sram_r_en, 0);
        check("wr_issue_addr", bus.sram_w_addr, 32'h805);
        check("wr_issue_data", bus.sram_w_d, PAT_A5);
        tick();
        check("wr_wait_en", {bus.sram_w_en, bus.sram_r_en}, 0);
        check("wr_wait_ack", bus.wr_ack, 0);
        check("wr_wait_addr", bus.sram_w_addr, 32'h805);
        tick();
        check("wr_resp_ack", bus.wr_ack, 1);
        check("wr_resp_err", bus.err_addr, 0);
        bus.wr_req = 1'b0;
        tick();
        check("wr_idle_ack", bus.wr_ack, 0);

        // Reader 2 reads back 0x805
        bus.rd_addr[2*32 +: 32] = 32'h805;
        bus.rd_req = 4'b0100;
        tick();
        check("rd_issue_ren", bus.sram_r_en, 1);
        check("rd_issue_wen", bus.sram_w_en, 0);
        check("rd_issue_addr", bus.sram_r_addr, 32'h805);
        tick();
        check("rd_wait_ack", bus.rd_ack, 0);
        tick();
        check("rd_resp_ack", bus.rd_ack, 4'b0100);
        check("rd_resp_data", bus.rd_data, PAT_A5);
        check("rd_resp_err", bus.err_addr, 0);
        bus.rd_req = '0;
        tick();
        check("rd_idle_ack", bus.rd_ack, 0);
        check("rd_hold_data", bus.rd_data, PAT_A5);

        // Reset so round-robin starts at reader 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Round-robin among readers 0, 2, 3
        bus.rd_addr[0*32 +: 32] = 32'h10;
        bus.rd_addr[2*32 +: 32] = 32'h20;
        bus.rd_addr[3*32 +: 32] = 32'h30;
        bus.rd_req = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("rr%0d", k), ack, n);
            check($sformatf("rr%0d_grant", k), ack, {1'b0, rr_exp[k]});
            check($sformatf("rr%0d_cycles", k), n, (k == 0) ? 3 : 4);
        end
        bus.rd_req = '0;
        tick();

        // Write priority with streak limit 2, reader 1 pending
        wcount = 0;
        bus.rd_addr[1*32 +: 32] = 32'h100;
        bus.wr_addr = 32'h100;
        bus.wr_data = wdata(0);
        bus.wr_req  = 1'b1;
        bus.rd_req  = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            wait_ack($sformatf("pr%0d", k), ack, n);
            check($sformatf("pr%0d_grant", k), ack, pr_exp[k]);
            check($sformatf("pr%0d_cycles", k), n, (k == 0) ? 3 : 4);
            if (ack[NR]) begin
                wcount++;
                bus.wr_addr = 32'h100 + 32'(wcount);
                bus.wr_data = wdata(wcount);
            end else begin
                check($sformatf("pr%0d_rdata", k), bus.rd_data, wdata(0));
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = '0;
        tick();

        // Invalid bank row, read (row 6)
        bus.rd_addr[0*32 +: 32] = 32'h3000;
        bus.rd_req = 4'b0001;
        tick();
        check("bad_rd_ack", bus.rd_ack, 4'b0001);
        check("bad_rd_err", bus.err_addr, 1);
        check("bad_rd_en", {bus.sram_w_en, bus.sram_r_en}, 0);
        check("bad_rd_data", bus.rd_data, 0);
        bus.rd_req = '0;
        tick();
        check("bad_rd_idle", {bus.rd_ack, bus.err_addr, bus.sram_r_en}, 0);

        // Invalid bank row, write (row 7)
        bus.wr_addr = 32'h3800;
        bus.wr_data = PAT_A5;
        bus.wr_req  = 1'b1;
        tick();
        check("bad_wr_ack", bus.wr_ack, 1);
        check("bad_wr_err", bus.err_addr, 1);
        check("bad_wr_en", {bus.sram_w_en, bus.sram_r_en}, 0);
        bus.wr_req = 1'b0;
        tick();
        check("bad_wr_idle", {bus.wr_ack, bus.err_addr, bus.sram_w_en}, 0);

        // Reset during WAIT of a read
        ctrl_stall = 1'b1;
        bus.rd_addr[3*32 +: 32] = 32'h805;
        bus.rd_req = 4'b1000;
        tick();
        check("rst_issue_ren", bus.sram_r_en, 1);
        tick();
        tick();
        check("rst_wait_ack", bus.rd_ack, 0);
        reset      = 1'b1;
        bus.rd_req = '0;
        tick();
        check_quiet("rst_wait");
        reset      = 1'b0;
        ctrl_stall = 1'b0;
        bus.rd_addr[0*32 +: 32] = 32'h805;
        bus.rd_req = 4'b1001;
        wait_ack("post_rst", ack, n);
        check("post_rst_grant", ack, 5'b00001);
        check("post_rst_cycles", n, 3);
        check("post_rst_data", bus.rd_data, PAT_A5);
        bus.rd_req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_sram_arbiter.md
# input_sram_arbiter

Request arbiter and sequencer in front of the input-activation SRAM controller. It shares the controller's single read/write port between one fill (DMA) write requester and NUM_READERS PE-side read requesters. Each transaction is issued as a one-cycle enable pulse, and the arbiter waits for the controller's completion strobe before returning a one-cycle acknowledge to the winner. Write priority, reader round-robin and a write-streak limit bound the wait for every requester.

## Interface
- NUM_READERS, 4, number of read requesters (2..8)
- WRITE_BURST_MAX, 8, max consecutive write grants while any read is pending
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr_req  in  1  write request, level, held until wr_ack
- wr_addr  in  32  write word address; bits [13:11] bank row, [10:0] word
- wr_data  in  128  write data
- wr_ack  out  1  one-cycle pulse, write complete
- rd_req  in  NUM_READERS  per-reader read request, level, held until its rd_ack bit
- rd_addr  in  32*NUM_READERS  reader i address at [32i+31:32i]
- rd_ack  out  NUM_READERS  one-hot one-cycle pulse, rd_data valid
- rd_data  out  128  registered read data
- err_addr  out  1  one-cycle pulse with the ack of a transaction rejected for bank row >= 6
- sram_w_addr, sram_r_addr  out  32  controller addresses
- sram_w_d  out  128  controller write data
- sram_w_en, sram_r_en  out  1  controller enables, one-cycle pulses
- sram_r_d  in  128  controller read data
- sram_d_ready, sram_w_done  in  1  controller completion strobes

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - If wr_req is high and (write_streak < WRITE_BURST_MAX or no rd_req bit set): grant the write.
  - Otherwise, if any rd_req bit is set: grant a reader by round-robin, searching from last_reader+1 modulo NUM_READERS.
  - Otherwise: stay in IDLE.
- Grant capture: op type, reader index, address and write data are registered.
- Invalid bank row: if captured address bits [13:11] >= 6, go directly to RESP with err_addr=1 and no SRAM enable. A rejected read returns rd_data=0.
- ISSUE: exactly one of sram_w_en / sram_r_en is 1. sram_w_addr = sram_r_addr = captured address; sram_w_d = captured data.
- WAIT: both enables are 0. Addresses and data are held unchanged through ISSUE and WAIT. Stay until sram_w_done (write) or sram_d_ready (read). The strobe not matching the op is ignored.
- Read data: on the edge where sram_d_ready is high in WAIT, rd_data <= sram_r_d.
- RESP: wr_ack or rd_ack[idx] = 1 for one cycle. Requests are not sampled in RESP.
- write_streak:
  - increments (saturating at WRITE_BURST_MAX) on each write grant;
  - clears on each read grant;
  - clears when IDLE sees wr_req low.
- last_reader updates on each read grant.
- rd_data holds its value until the next read completion.

## Timing
- Reset values: all outputs 0; state IDLE; write_streak 0; last_reader NUM_READERS-1, so reader 0 wins first.
- Reset asserted in any state aborts the transaction with no ack. Requesters must re-request after reset.
- Latency, request seen in IDLE at cycle T:
  - T+1: ISSUE (enable high).
  - T+2: WAIT (controller strobe arrives).
  - T+3: RESP (ack).
  - T+4: IDLE (next arbitration).
- Throughput: 4 cycles per transaction with a 1-cycle controller. Longer controller latency extends WAIT.
- Rejected (invalid bank row) transaction: ack at T+1, IDLE at T+2.
- Requesters drop req on the edge after seeing their ack, so no duplicate grant can occur.
- Requests raised during ISSUE, WAIT or RESP wait for the next IDLE.
- Simultaneous wr_req and rd_req in IDLE: the write wins unless the streak limit is reached.

## Test plan
- Write: wr_req, addr 0x0000_0805, data 0xA5..A5 -> sram_w_en at T+1 with w_addr 0x805; after w_done, wr_ack at T+3; err_addr 0.
- Read-back: reader 2 reads 0x805 -> sram_r_en at T+1; rd_ack = 4'b0100 at T+3; rd_data = 0xA5..A5.
- Round-robin: readers 0, 2, 3 request continuously -> grant order 0, 2, 3, 0, 2; one ack per 4 cycles.
- Write priority and streak limit (WRITE_BURST_MAX=2): wr_req held with new addresses, reader 1 pending -> order W, W, R1, W, W, R1.
- Invalid bank row: reader 0, addr 0x3000 (row 6) -> no sram enable; rd_ack[0] and err_addr at T+1; rd_data 0.
- Reset during WAIT of a read -> no rd_ack; all outputs 0 next cycle; a fresh request is then served normally, reader 0 first.
